// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: ID-stage hazard and forwarding unit. Tracks
// in-flight destination tags in a DEPTH-entry shift scoreboard and derives
// per-operand bypass selects, load-use stalls and mul/div busy stalls.
//
// Ports:
//   clock, resetn        : rising-edge clock, synchronous active-low reset
//   id_valid, id_flush   : ID holds a real instruction / annul it (flush)
//   id_rs/rt, id_uses_*  : source registers and whether each is read
//   id_wreg, id_wn       : destination write enable and register
//   id_is_load           : instruction is a load
//   id_is_md, id_uses_md : starts a mul/div / reads the mul/div result
//   fwda, fwdb           : 0 = register file, k = stage-k result
//   stall, issue         : freeze PC and IF/ID / ID advances this cycle
//   md_busy              : mul/div unit occupied
//
// Build option: define HAZ_MD_EN to build the mul/div occupancy counter;
// without it md_busy is tied low and id_is_md/id_uses_md are ignored.

module pipe_hazard_scoreboard #(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int RN_W       = 5,
  parameter int MD_LAT     = 4,
  localparam int FW_W      = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            id_valid,
  input  logic [RN_W-1:0] id_rs,
  input  logic [RN_W-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            id_wreg,
  input  logic [RN_W-1:0] id_wn,
  input  logic            id_is_load,
  input  logic            id_is_md,
  input  logic            id_uses_md,
  input  logic            flush,
  output logic [FW_W-1:0] fwda,
  output logic [FW_W-1:0] fwdb,
  output logic            stall,
  output logic            issue,
  output logic            md_busy
);

  typedef struct packed {
    logic            v;
    logic            wr;
    logic [RN_W-1:0] wn;
    logic            ld;
  } sb_ent_t;

  sb_ent_t sb [1:DEPTH];

  logic [FW_W-1:0] sel_a;
  logic [FW_W-1:0] sel_b;
  logic            haz_a;
  logic            haz_b;
  logic            md_haz;
  logic            go;

  function automatic logic hit(
    input sb_ent_t         e,
    input logic [RN_W-1:0] rn,
    input logic            use_r
  );
    return use_r & e.v & e.wr &
           (e.wn != '0) & (e.wn == rn);
  endfunction

  // Walk oldest to youngest so the
  // youngest matching stage wins.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (hit(sb[k], id_rs, id_uses_rs)) begin
        sel_a = FW_W'(k);
        haz_a = sb[k].ld && (k < LOAD_STAGE);
      end
      if (hit(sb[k], id_rt, id_uses_rt)) begin
        sel_b = FW_W'(k);
        haz_b = sb[k].ld && (k < LOAD_STAGE);
      end
    end
  end

`ifdef HAZ_MD_EN
  localparam int MD_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  logic [MD_W-1:0] md_cnt;
  logic [MD_W-1:0] md_nxt;
  logic            md_load;

  assign md_busy = (md_cnt != '0);
  assign md_haz  = md_busy & (id_is_md | id_uses_md);
  // A new op can only issue once the
  // counter has drained, so load and
  // decrement never coincide.
  assign md_load = issue & id_is_md;

  always_comb begin
    md_nxt = md_cnt;
    unique case (1'b1)
      md_load: md_nxt = MD_W'(MD_LAT - 1);
      md_busy: md_nxt = md_cnt - 1'b1;
      default: md_nxt = md_cnt;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      md_cnt <= '0;
    end else begin
      md_cnt <= md_nxt;
    end
  end
`else
  logic unused_md;

  assign unused_md = id_is_md ^ id_uses_md;
  assign md_busy   = 1'b0;
  assign md_haz    = 1'b0;
`endif

  assign go    = id_valid & ~flush;
  assign stall = go & (haz_a | haz_b | md_haz);
  assign issue = go & ~stall;

  assign fwda = stall ? '0 : sel_a;
  assign fwdb = stall ? '0 : sel_b;

  // Older entries always advance; a
  // stalled or annulled slot enters
  // as a bubble.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int k = 1; k <= DEPTH; k++) begin
        sb[k] <= '0;
      end
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        sb[k] <= sb[k-1];
      end
      if (issue) begin
        sb[1] <= '{v:  1'b1,
                   wr: id_wreg,
                   wn: id_wn,
                   ld: id_is_load};
      end else begin
        sb[1] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard: directed and random stimulus for
// pipe_hazard_scoreboard, checked against an issue-history model.

module tb_pipe_hazard_scoreboard;

  localparam int DEPTH  = 3;
  localparam int LS     = 2;
  localparam int RN_W   = 5;
  localparam int MD_LAT = 4;
  localparam int FW_W   = $clog2(DEPTH + 1);
`ifdef HAZ_MD_EN
  localparam int MD_ON  = 1;
`else
  localparam int MD_ON  = 0;
`endif

  logic            clock = 1'b1;
  logic            resetn;
  logic            id_valid;
  logic [RN_W-1:0] id_rs, id_rt, id_wn;
  logic            id_uses_rs, id_uses_rt;
  logic            id_wreg, id_is_load;
  logic            id_is_md, id_uses_md;
  logic            flush;
  logic [FW_W-1:0] fwda, fwdb;
  logic            stall, issue, md_busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  pipe_hazard_scoreboard #(
    .DEPTH(DEPTH), .LOAD_STAGE(LS),
    .RN_W(RN_W), .MD_LAT(MD_LAT)
  ) dut (
    .clock(clock), .resetn(resetn),
    .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt),
    .id_wreg(id_wreg), .id_wn(id_wn),
    .id_is_load(id_is_load),
    .id_is_md(id_is_md),
    .id_uses_md(id_uses_md),
    .flush(flush),
    .fwda(fwda), .fwdb(fwdb),
    .stall(stall), .issue(issue),
    .md_busy(md_busy)
  );

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d",
               nm, cyc, act, exp);
    end
  endtask

  // Model: per-cycle log of what issued.
  // The instruction that issued in cycle
  // c-k sits in stage k during cycle c,
  // unless a reset cycle came after it.
  bit lv  [0:4095];
  bit lwr [0:4095];
  int lwn [0:4095];
  bit lld [0:4095];
  int last_rst = -1;
  int md_last  = -100000;

  function automatic void pick(input int rn,
                               input bit use_r,
                               input int c,
                               output int sel,
                               output bit haz);
    sel = 0;
    haz = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      int o;
      o = c - k;
      if (sel == 0 && use_r && o > last_rst &&
          lv[o] && lwr[o] && lwn[o] != 0 &&
          lwn[o] == rn) begin
        sel = k;
        haz = lld[o] && (k < LS);
      end
    end
  endfunction

  always @(negedge clock) begin : cmp
    int c, sa, sb, e_fa, e_fb;
    bit ha, hb, busy, mdh, go, e_st, e_is;
    c = cyc;
    pick(int'(id_rs), id_uses_rs, c, sa, ha);
    pick(int'(id_rt), id_uses_rt, c, sb, hb);
    busy = MD_ON != 0 && md_last > last_rst &&
           (c - md_last) >= 1 &&
           (c - md_last) <= MD_LAT - 1;
    mdh  = busy && (id_is_md || id_uses_md);
    go   = id_valid && !flush;
    e_st = go && (ha || hb || mdh);
    e_is = go && !e_st;
    e_fa = e_st ? 0 : sa;
    e_fb = e_st ? 0 : sb;
    if (c >= 1) begin
      check("m_fwda", int'(fwda), e_fa);
      check("m_fwdb", int'(fwdb), e_fb);
      check("m_stall", int'(stall), int'(e_st));
      check("m_issue", int'(issue), int'(e_is));
      check("m_mdbusy", int'(md_busy), int'(busy));
    end
    if (!resetn) begin
      last_rst = c;
      lv[c] = 0;
    end else begin
      lv[c]  = e_is;
      lwr[c] = id_wreg;
      lwn[c] = int'(id_wn);
      lld[c] = id_is_load;
      if (e_is && id_is_md) md_last = c;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    id_valid   = 0;
    id_rs      = '0;
    id_rt      = '0;
    id_uses_rs = 0;
    id_uses_rt = 0;
    id_wreg    = 0;
    id_wn      = '0;
    id_is_load = 0;
    id_is_md   = 0;
    id_uses_md = 0;
    flush      = 0;
  endtask

  task automatic wr(input int rn, input bit ld);
    idle();
    id_valid   = 1;
    id_wreg    = 1;
    id_wn      = RN_W'(rn);
    id_is_load = ld;
  endtask

  initial begin
    idle();
    resetn   = 0;
    id_valid = 1;
    step();
    settle();
    check("rst_stall", int'(stall), 0);
    check("rst_fwda", int'(fwda), 0);
    check("rst_fwdb", int'(fwdb), 0);
    step();
    resetn = 1;
    settle();
    check("rst_issue", int'(issue), 1);

    // ALU chain: add r3 then readers
    step(); wr(3, 0);
    settle(); check("alu_issue", int'(issue), 1);
    step(); idle();
    id_valid = 1; id_rs = 3; id_uses_rs = 1;
    settle(); check("alu_fwd1", int'(fwda), 1);
    step(); settle(); check("alu_fwd2", int'(fwda), 2);
    step(); settle(); check("alu_fwd3", int'(fwda), 3);
    step(); settle(); check("alu_fwd0", int'(fwda), 0);

    // Load-use: lw r5 then reader of rt
    step(); wr(5, 1);
    settle(); check("lu_ld_issue", int'(issue), 1);
    step(); idle();
    id_valid = 1; id_rt = 5; id_uses_rt = 1;
    settle();
    check("lu_stall", int'(stall), 1);
    check("lu_noissue", int'(issue), 0);
    check("lu_fwdb0", int'(fwdb), 0);
    step(); settle();
    check("lu_release", int'(stall), 0);
    check("lu_fwdb2", int'(fwdb), 2);
    check("lu_issue", int'(issue), 1);

    // Youngest writer wins; r0 never hazards
    step(); wr(4, 0);
    step(); wr(4, 0);
    step(); idle();
    id_valid = 1; id_rs = 4; id_uses_rs = 1;
    settle(); check("prio_fwda", int'(fwda), 1);
    step(); wr(0, 1);
    step(); idle();
    id_valid = 1; id_rs = 0; id_uses_rs = 1;
    settle();
    check("r0_fwda", int'(fwda), 0);
    check("r0_stall", int'(stall), 0);

    // Flush beats a load-use stall
    step(); wr(7, 1);
    step(); wr(6, 1);
    id_rt = 7; id_uses_rt = 1; flush = 1;
    settle();
    check("fl_issue", int'(issue), 0);
    check("fl_stall", int'(stall), 0);
    step(); idle();
    id_valid = 1; id_rs = 6; id_uses_rs = 1;
    settle();
    check("fl_fwda", int'(fwda), 0);
    check("fl_nostall", int'(stall), 0);

    // Reset mid-flight drops tags
    step(); wr(9, 0);
    step(); idle(); resetn = 0;
    step(); resetn = 1; idle();
    id_valid = 1; id_rs = 9; id_uses_rs = 1;
    settle(); check("mrst_fwda", int'(fwda), 0);

    // Mul/div occupancy
    step(); idle(); id_valid = 1; id_is_md = 1;
    settle();
    check("md_issue", int'(issue), 1);
    check("md_idle", int'(md_busy), 0);
    step(); idle();
    id_valid = 1; id_is_md = 1; id_uses_md = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("md_stall", int'(stall), MD_ON);
      check("md_wait", int'(issue), 1 - MD_ON);
      step();
    end
    settle();
    check("md_b2b_issue", int'(issue), 1);
    check("md_b2b_stall", int'(stall), 0);
    step(); idle(); id_valid = 1; id_uses_md = 1;
    settle();
    check("md_rebusy", int'(md_busy), MD_ON);
    check("md_restall", int'(stall), MD_ON);

    // Random traffic, model-checked
    for (int i = 0; i < 300; i++) begin
      step();
      resetn     = ($urandom_range(0, 59) != 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      id_rs      = RN_W'($urandom_range(0, 3));
      id_rt      = RN_W'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1));
      id_uses_rt = 1'($urandom_range(0, 1));
      id_wreg    = 1'($urandom_range(0, 1));
      id_wn      = RN_W'($urandom_range(0, 3));
      id_is_load = ($urandom_range(0, 2) == 0);
      id_is_md   = ($urandom_range(0, 7) == 0);
      id_uses_md = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 9) == 0);
    end
    step(); idle(); resetn = 1;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
